uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and parity-mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: flags the last clock of each ClksPerBit-long serial bit.
module uart_baud_cnt #(
  parameter int ClksPerBit = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_bit_done
);

  localparam int CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
    end
  end

  // Must not depend on i_clear: the owner derives i_clear from this flag.
  assign o_bit_done = i_en && (r_cnt == LastCnt);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops characters from a FIFO and serialises start, data
// (LSB first), optional parity and stop bits on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int ClksPerBit = 16,
  parameter int Parity     = 0,
  parameter int StopBits   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_en,
  input  logic [DataWidth-1:0] i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  output logic                 o_tx,
  output logic                 o_busy
);

  if (DataWidth < 5 || DataWidth > 9) begin : g_bad_data_width
    $fatal(1, "uart_tx: DataWidth must be 5..9");
  end
  if (ClksPerBit < 2) begin : g_bad_clks_per_bit
    $fatal(1, "uart_tx: ClksPerBit must be >= 2");
  end
  if (Parity != PARITY_NONE && Parity != PARITY_EVEN && Parity != PARITY_ODD) begin : g_bad_parity
    $fatal(1, "uart_tx: Parity must be 0, 1 or 2");
  end
  if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx: StopBits must be 1 or 2");
  end

  localparam int BitW = $clog2(DataWidth);
  localparam logic [BitW-1:0] LastData = BitW'(DataWidth - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(StopBits - 1);
  localparam logic            ParOdd   = (Parity == PARITY_ODD);

  uart_state_e          r_state;
  uart_state_e          w_next;
  logic [DataWidth-1:0] r_shift;
  logic [BitW-1:0]      r_bit_cnt;
  logic                 r_par;
  logic                 r_tx;
  logic                 w_rd_en;
  logic                 w_tx_next;
  logic                 w_bit_done;
  logic                 w_clear;
  logic                 w_en;

  assign w_en    = (r_state != S_IDLE);
  assign w_clear = (w_next != r_state);

  uart_baud_cnt #(
    .ClksPerBit(ClksPerBit)
  ) u_baud (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_clear),
    .i_en      (w_en),
    .o_bit_done(w_bit_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Pop is gated by reset so the FIFO never loses a word while held in reset.
  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_tx_en && !i_fifo_empty && !i_rst) begin
          w_rd_en = 1'b1;
          w_next  = S_START;
        end
      end
      S_START:  if (w_bit_done) w_next = S_DATA;
      S_DATA: begin
        if (w_bit_done && r_bit_cnt == LastData) begin
          w_next = (Parity != PARITY_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (w_bit_done) w_next = S_STOP;
      S_STOP:   if (w_bit_done && r_bit_cnt == LastStop) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Line value is chosen from the state being entered so o_tx aligns with r_state.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = (r_state == S_DATA && w_bit_done) ? r_shift[1] : r_shift[0];
      S_PARITY: w_tx_next = r_par;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
    end else begin
      r_tx <= w_tx_next;
      if (w_clear) begin
        r_bit_cnt <= '0;
      end else if (w_bit_done) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_rd_en) begin
        r_shift <= i_fifo_data;
        r_par   <= (^i_fifo_data) ^ ParOdd;
      end else if (r_state == S_DATA && w_bit_done) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  assign o_tx         = r_tx;
  assign o_busy       = (r_state != S_IDLE);
  assign o_fifo_rd_en = w_rd_en;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations fed from small FIFO models, with
// every serial line cycle compared against a frame model built from the bit rules.
module tb_uart_tx;

  localparam int NDUT = 4;
  localparam int CPB[NDUT] = '{4, 4, 4, 3};
  localparam int PAR[NDUT] = '{0, 1, 2, 0};
  localparam int STB[NDUT] = '{1, 1, 1, 2};

  logic            clk = 1'b0;
  logic            rst;
  logic            tx_en;
  logic [NDUT-1:0] w_tx;
  logic [NDUT-1:0] w_busy;
  logic [NDUT-1:0] w_rd;
  logic [NDUT-1:0] f_empty;
  logic [7:0]      f_data [NDUT];
  logic [7:0]      mem [NDUT][64];
  int              wp [NDUT];
  int              rp [NDUT] = '{default: 0};
  int              tests;
  int              fails;
  int              pops0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign f_empty[g] = (rp[g] == wp[g]);
    assign f_data[g]  = mem[g][rp[g][5:0]];

    uart_tx #(
      .DataWidth (8),
      .ClksPerBit(CPB[g]),
      .Parity    (PAR[g]),
      .StopBits  (STB[g])
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tx_en     (tx_en),
      .i_fifo_data (f_data[g]),
      .i_fifo_empty(f_empty[g]),
      .o_fifo_rd_en(w_rd[g]),
      .o_tx        (w_tx[g]),
      .o_busy      (w_busy[g])
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (w_rd[k]) rp[k] <= rp[k] + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int frame_len(int k);
    return (1 + 8 + ((PAR[k] != 0) ? 1 : 0) + STB[k]) * CPB[k];
  endfunction

  // Serial value of bit slot `slot` of a frame carrying d.
  function automatic logic exp_bit(int k, logic [7:0] d, int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (PAR[k] != 0 && slot == 9) return (^d) ^ (PAR[k] == 2);
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic push(int k, logic [7:0] d);
    mem[k][wp[k][5:0]] = d;
    wp[k] = wp[k] + 1;
  endtask

  task automatic wait_pop(int k);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (w_rd[k]) break;
      tick();
    end
    chk("pop", k, w_rd[k], 1);
  endtask

  // Entered in the pop cycle; leaves in the single idle cycle after the frame.
  task automatic run_frame(int k, logic [7:0] d, int drop_at);
    int len;
    len = frame_len(k);
    for (int n = 1; n <= len; n++) begin
      tick();
      if (n == drop_at) tx_en = 1'b0;
      chk("tx", k, w_tx[k], exp_bit(k, d, (n - 1) / CPB[k]));
      chk("busy", k, w_busy[k], 1);
      chk("rd_mid", k, w_rd[k], 0);
    end
    tick();
    chk("idle_tx", k, w_tx[k], 1);
    chk("idle_busy", k, w_busy[k], 0);
  endtask

  initial begin
    logic [7:0] b [3];
    int k;
    int n;
    tests = 0;
    fails = 0;
    pops0 = 0;
    for (int i = 0; i < NDUT; i++) wp[i] = 0;
    rst   = 1'b1;
    tx_en = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_tx", i, w_tx[i], 1);
      chk("rst_busy", i, w_busy[i], 0);
      chk("rst_rd", i, w_rd[i], 0);
    end

    // A character waiting while reset is held must not be popped.
    push(0, 8'hA5);
    #1;
    chk("rst_hold_rd", 0, w_rd[0], 0);
    rst = 1'b0;
    wait_pop(0);
    pops0++;
    run_frame(0, 8'hA5, 0);
    chk("after_rd", 0, w_rd[0], 0);
    chk("pop_count", 0, rp[0], pops0);

    push(1, 8'hA5);
    wait_pop(1);
    run_frame(1, 8'hA5, 0);
    push(2, 8'hA5);
    wait_pop(2);
    run_frame(2, 8'hA5, 0);
    push(3, 8'h6C);
    wait_pop(3);
    run_frame(3, 8'h6C, 0);

    // Back-to-back: the single idle cycle is also the second pop cycle.
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_pop(0);
    pops0++;
    run_frame(0, 8'h00, 0);
    chk("b2b_pop", 0, w_rd[0], 1);
    pops0++;
    run_frame(0, 8'hFF, 0);
    chk("b2b_end_rd", 0, w_rd[0], 0);

    for (int i = 0; i < 100; i++) begin
      tick();
      chk("empty_rd", 0, w_rd[0], 0);
      chk("empty_tx", 0, w_tx[0], 1);
      chk("empty_busy", 0, w_busy[0], 0);
    end

    // Reset during the third data bit of 0x3B (that bit is 0).
    push(0, 8'h3B);
    push(0, 8'hC4);
    wait_pop(0);
    pops0++;
    for (int i = 1; i <= 3 * CPB[0] + 2; i++) tick();
    chk("pre_rst_tx", 0, w_tx[0], 0);
    rst = 1'b1;
    #1;
    chk("async_tx", 0, w_tx[0], 1);
    chk("async_busy", 0, w_busy[0], 0);
    chk("async_rd", 0, w_rd[0], 0);
    tick();
    chk("rst_no_pop", 0, rp[0], pops0);
    rst = 1'b0;
    wait_pop(0);
    pops0++;
    run_frame(0, 8'hC4, 0);

    // i_tx_en dropped during START with two characters queued.
    push(0, 8'h5A);
    push(0, 8'h96);
    wait_pop(0);
    pops0++;
    run_frame(0, 8'h5A, 2);
    chk("en_low_rd", 0, w_rd[0], 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en_low_hold_rd", 0, w_rd[0], 0);
      chk("en_low_tx", 0, w_tx[0], 1);
    end
    chk("en_low_pops", 0, rp[0], pops0);
    tx_en = 1'b1;
    wait_pop(0);
    pops0++;
    run_frame(0, 8'h96, 0);

    for (int r = 0; r < 6; r++) begin
      k = int'($urandom_range(0, NDUT - 1));
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) begin
        b[i] = 8'($urandom);
        push(k, b[i]);
      end
      wait_pop(k);
      for (int i = 0; i < n; i++) begin
        run_frame(k, b[i], 0);
        if (i < n - 1) chk("rnd_b2b_pop", k, w_rd[k], 1);
      end
      chk("rnd_end_rd", k, w_rd[k], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
